dmem_port_arbiter: RTL and testbench
====================================

# dmem_port_arbiter

Two-requester arbiter and access sequencer for the byte-addressed data memory (`Data_Memory`). It lets the CPU MEM stage (port 0) and a loader/debug engine (port 1) share the single memory port. It also range-checks each access and returns registered read data with a fixed two-cycle latency. It sits between the requesters and the memory, and it is the only block that drives the memory's address, data and enable inputs.

## Interface
- `DEPTH`, 32: memory size in bytes; a word access is legal when `addr <= DEPTH-4`.
- `clk_i` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `p0_req_i` / `p1_req_i` in 1: request valid; held with its fields stable until granted.
- `p0_we_i` / `p1_we_i` in 1: 1 = word write, 0 = word read.
- `p0_addr_i` / `p1_addr_i` in 32: byte address.
- `p0_wdata_i` / `p1_wdata_i` in 32: write data.
- `p0_gnt_o` / `p1_gnt_o` out 1: combinational grant; the request is accepted at the rising edge where `req & gnt`.
- `p0_rvalid_o` / `p1_rvalid_o` out 1: one-cycle response pulse, issued for both reads and writes.
- `p0_rdata_o` / `p1_rdata_o` out 32: read data, valid with `rvalid`; 0 for writes and errors.
- `p0_err_o` / `p1_err_o` out 1: out-of-range flag, valid with `rvalid`.
- `mem_addr_o` out 32: memory `addr_i`.
- `mem_data_o` out 32: memory `data_i`.
- `mem_write_o` out 1: memory `MemWrite_i`.
- `mem_read_o` out 1: memory `MemRead_i`.
- `mem_data_i` in 32: memory `data_o`.
- `busy_o` out 1: high while in ACCESS.

## Operation
**Request latch**
- The latch holds port id, we, addr, wdata, and an error bit computed at accept as `addr > DEPTH-4`.

**FSM**
- States are IDLE and ACCESS.
- From IDLE: accept → ACCESS.
- From ACCESS: accept → ACCESS (back-to-back); otherwise → IDLE.

**Grant**
- Grant is offered in both states; at most one `gnt` is high per cycle.
- With only one requester, that port is granted.
- On contention, the Configuration policy decides.

**ACCESS cycle**
- `mem_addr_o`/`mem_data_o` come from the latch.
- `mem_write_o = we & ~err`.
- `mem_read_o = ~we & ~err`.
- In IDLE, all mem outputs are 0.

**Response**
- At the edge ending an ACCESS cycle, the latched port's `rvalid` rises for one cycle.
- `rdata` is `mem_data_i` for a legal read, otherwise 0.
- `err` is the latched error bit.
- The other port's `rvalid`/`rdata`/`err` are 0.

**Errored accesses**
- They never assert `mem_write_o`/`mem_read_o`, so memory is untouched.

## Timing
**Reset values**
- State IDLE; latch cleared.
- All `gnt`, `rvalid`, `err`, `busy_o`, `mem_write_o`, `mem_read_o` are 0; all `rdata` and `mem_*` data/address outputs are 0.
- RR pointer = "last granted port 1".

**Latency**
- Accept at edge N, ACCESS during cycle N..N+1, `rvalid` during cycle N+1..N+2.
- Throughput is one access per cycle.

**Write/read ordering**
- Memory writes land on the falling edge inside the ACCESS cycle.
- A read accepted right after a write to the same address returns the new data.

**Reset mid-operation**
- An in-flight ACCESS is dropped: no `rvalid` is issued, and `mem_write_o` is 0 from the reset cycle.
- A memory write already performed on that cycle's falling edge is not undone.
- `reset` does not clear memory contents; the memory's own reset does.

**Simultaneous events**
- Accept and response for different (or the same) ports may occur in the same cycle.
- A requester must not drop `req` before `gnt`. If it does, behaviour is defined only as "not accepted".

## Configuration
**`DMEM_ARB_RR_EN` defined**
- Round-robin on contention: the port not granted most recently wins.
- The pointer updates on every accepted grant, including uncontended ones.

**Not defined**
- Fixed priority: port 0 always wins contention.
- Port 1 is granted only when `p0_req_i` is low.
- No pointer register exists.

## Test plan
- **Reset then idle:** all outputs 0 and `busy_o = 0` for 5 cycles.
- **Port 0 write then read, no contention:**
  - Write addr 8, data 0xDEADBEEF.
  - Next cycle, read addr 8 → `p0_rvalid_o` pulses twice, `p0_rdata_o = 0xDEADBEEF` on the second pulse, `err = 0`.
- **Out of range:** port 1 writes addr 29 (DEPTH = 32) → `p1_err_o = 1`, `mem_write_o` never high; a read of addr 28 still returns the prior value.
- **Contention with `DMEM_ARB_RR_EN`:**
  - Both ports request continuously: reads at addr 0 and addr 4 respectively.
  - Grants alternate p0, p1, p0, p1; responses alternate ports each cycle, one cycle behind the grants.
- **Contention without the macro:** both request for 4 cycles → `p0_gnt_o` high all 4 cycles, `p1_gnt_o` granted only in cycle 5 after p0 drops its request.
- **Reset mid-access:**
  - Port 0 read accepted at edge N, `reset` high in cycle N..N+1.
  - Result: no `p0_rvalid_o`, all outputs at reset values at N+2, next request served normally.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: two-port arbiter and access sequencer for Data_Memory.
// Port 0 is the CPU MEM stage and port 1 is the loader/debug engine. Each
// accepted request occupies one ACCESS cycle. Its response (rvalid/rdata/err)
// is registered and appears on the following cycle. Accesses that are out of
// range are flagged and never reach the memory enables.
// Optional feature macro: DMEM_ARB_RR_EN selects round-robin arbitration on
// contention. When the macro is undefined, port 0 has fixed priority.

module dmem_port_arbiter #(
    parameter int unsigned DEPTH = 32
) (
    input  logic        clk_i,
    input  logic        reset,
    input  logic        p0_req_i,
    input  logic        p0_we_i,
    input  logic [31:0] p0_addr_i,
    input  logic [31:0] p0_wdata_i,
    input  logic        p1_req_i,
    input  logic        p1_we_i,
    input  logic [31:0] p1_addr_i,
    input  logic [31:0] p1_wdata_i,
    output logic        p0_gnt_o,
    output logic        p1_gnt_o,
    output logic        p0_rvalid_o,
    output logic [31:0] p0_rdata_o,
    output logic        p0_err_o,
    output logic        p1_rvalid_o,
    output logic [31:0] p1_rdata_o,
    output logic        p1_err_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic        mem_write_o,
    output logic        mem_read_o,
    input  logic [31:0] mem_data_i,
    output logic        busy_o
);

    localparam int unsigned DW       = 32;
    localparam logic [31:0] MAX_ADDR = 32'(DEPTH - 4);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic            lat_port_q, lat_port_d;
    logic            lat_we_q, lat_we_d;
    logic [DW-1:0]   lat_addr_q, lat_addr_d;
    logic [DW-1:0]   lat_wdata_q, lat_wdata_d;
    logic            lat_err_q, lat_err_d;
    logic            p0_rvalid_q, p0_rvalid_d;
    logic [DW-1:0]   p0_rdata_q, p0_rdata_d;
    logic            p0_err_q, p0_err_d;
    logic            p1_rvalid_q, p1_rvalid_d;
    logic [DW-1:0]   p1_rdata_q, p1_rdata_d;
    logic            p1_err_q, p1_err_d;
    logic            accept;
    logic [DW-1:0]   rsp_data;

`ifdef DMEM_ARB_RR_EN
    logic            last_q, last_d;   // 1 = port 1 was granted most recently

    // Pointer register: remembers the port granted last
    always_ff @(posedge clk_i) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    // Grant selection; nothing is granted while reset is asserted
    always_comb begin
        p0_gnt_o = 1'b0;
        p1_gnt_o = 1'b0;
`ifdef DMEM_ARB_RR_EN
        last_d   = last_q;
        if (!reset) begin
            p0_gnt_o = p0_req_i & (~p1_req_i | last_q);
            p1_gnt_o = p1_req_i & (~p0_req_i | ~last_q);
        end
        if (p0_gnt_o) begin
            last_d = 1'b0;
        end else if (p1_gnt_o) begin
            last_d = 1'b1;
        end
`else
        if (!reset) begin
            p0_gnt_o = p0_req_i;
            p1_gnt_o = p1_req_i & ~p0_req_i;
        end
`endif
        accept = p0_gnt_o | p1_gnt_o;
    end

    // State, request latch and response registers
    always_ff @(posedge clk_i) begin
        if (reset) begin
            state_q     <= IDLE;
            lat_port_q  <= 1'b0;
            lat_we_q    <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            lat_err_q   <= 1'b0;
            p0_rvalid_q <= 1'b0;
            p0_rdata_q  <= '0;
            p0_err_q    <= 1'b0;
            p1_rvalid_q <= 1'b0;
            p1_rdata_q  <= '0;
            p1_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_port_q  <= lat_port_d;
            lat_we_q    <= lat_we_d;
            lat_addr_q  <= lat_addr_d;
            lat_wdata_q <= lat_wdata_d;
            lat_err_q   <= lat_err_d;
            p0_rvalid_q <= p0_rvalid_d;
            p0_rdata_q  <= p0_rdata_d;
            p0_err_q    <= p0_err_d;
            p1_rvalid_q <= p1_rvalid_d;
            p1_rdata_q  <= p1_rdata_d;
            p1_err_q    <= p1_err_d;
        end
    end

    // Next state, request capture and response generation
    always_comb begin
        state_d     = IDLE;
        lat_port_d  = lat_port_q;
        lat_we_d    = lat_we_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        lat_err_d   = lat_err_q;
        p0_rvalid_d = 1'b0;
        p0_rdata_d  = '0;
        p0_err_d    = 1'b0;
        p1_rvalid_d = 1'b0;
        p1_rdata_d  = '0;
        p1_err_d    = 1'b0;
        rsp_data    = '0;

        if (accept) begin
            state_d     = ACCESS;
            lat_port_d  = p1_gnt_o;
            lat_we_d    = p1_gnt_o ? p1_we_i    : p0_we_i;
            lat_addr_d  = p1_gnt_o ? p1_addr_i  : p0_addr_i;
            lat_wdata_d = p1_gnt_o ? p1_wdata_i : p0_wdata_i;
            lat_err_d   = (p1_gnt_o ? p1_addr_i : p0_addr_i) > MAX_ADDR;
        end

        if (state_q == ACCESS) begin
            if (!lat_we_q && !lat_err_q) begin
                rsp_data = mem_data_i;
            end
            if (lat_port_q) begin
                p1_rvalid_d = 1'b1;
                p1_rdata_d  = rsp_data;
                p1_err_d    = lat_err_q;
            end else begin
                p0_rvalid_d = 1'b1;
                p0_rdata_d  = rsp_data;
                p0_err_d    = lat_err_q;
            end
        end
    end

    // Memory drive; the enables are forced low in a reset cycle so that a dropped access cannot write
    always_comb begin
        mem_addr_o  = '0;
        mem_data_o  = '0;
        mem_write_o = 1'b0;
        mem_read_o  = 1'b0;
        if (state_q == ACCESS) begin
            mem_addr_o  = lat_addr_q;
            mem_data_o  = lat_wdata_q;
            mem_write_o = lat_we_q & ~lat_err_q & ~reset;
            mem_read_o  = ~lat_we_q & ~lat_err_q & ~reset;
        end
    end

    assign busy_o      = (state_q == ACCESS);
    assign p0_rvalid_o = p0_rvalid_q;
    assign p0_rdata_o  = p0_rdata_q;
    assign p0_err_o    = p0_err_q;
    assign p1_rvalid_o = p1_rvalid_q;
    assign p1_rdata_o  = p1_rdata_q;
    assign p1_err_o    = p1_err_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Testbench for dmem_port_arbiter: a table of per-cycle vectors plus
// hand-written reset-during-access sequences, against a behavioural byte memory.
// Build with DMEM_ARB_RR_EN defined to select the round-robin contention table.

module tb_dmem_port_arbiter;

    typedef struct packed {
        logic        r0, w0;
        logic [31:0] a0, d0;
        logic        r1, w1;
        logic [31:0] a1, d1;
    } in_t;

    typedef struct packed {
        logic        g0, g1, busy, mw, mr;
        logic [31:0] maddr, mdata;
        logic        v0;
        logic [31:0] rd0;
        logic        e0;
        logic        v1;
        logic [31:0] rd1;
        logic        e1;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    localparam int NV = 24;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
    logic [31:0] p0_addr = '0, p0_wdata = '0, p1_addr = '0, p1_wdata = '0;
    logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err;
    logic [31:0] p0_rdata, p1_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_write, mem_read, busy;
    logic [7:0]  mem [0:31];
    logic [4:0]  ma;
    out_t        got;
    vec_t        vecs [NV];
    int          n_tests = 0;
    int          n_fail  = 0;

    dmem_port_arbiter #(.DEPTH(32)) dut (
        .clk_i(clk), .reset(reset),
        .p0_req_i(p0_req), .p0_we_i(p0_we), .p0_addr_i(p0_addr), .p0_wdata_i(p0_wdata),
        .p1_req_i(p1_req), .p1_we_i(p1_we), .p1_addr_i(p1_addr), .p1_wdata_i(p1_wdata),
        .p0_gnt_o(p0_gnt), .p1_gnt_o(p1_gnt),
        .p0_rvalid_o(p0_rvalid), .p0_rdata_o(p0_rdata), .p0_err_o(p0_err),
        .p1_rvalid_o(p1_rvalid), .p1_rdata_o(p1_rdata), .p1_err_o(p1_err),
        .mem_addr_o(mem_addr), .mem_data_o(mem_wdata),
        .mem_write_o(mem_write), .mem_read_o(mem_read),
        .mem_data_i(mem_rdata), .busy_o(busy)
    );

    always #5 clk = ~clk;

    // Byte memory, big-endian words: writes on the falling edge, reads combinational
    always @(negedge clk) begin
        if (mem_write && mem_addr <= 32'd28) begin
            mem[mem_addr[4:0]]         <= mem_wdata[31:24];
            mem[mem_addr[4:0] + 5'd1]  <= mem_wdata[23:16];
            mem[mem_addr[4:0] + 5'd2]  <= mem_wdata[15:8];
            mem[mem_addr[4:0] + 5'd3]  <= mem_wdata[7:0];
        end
    end

    always_comb begin
        ma        = mem_addr[4:0];
        mem_rdata = '0;
        if (mem_read && mem_addr <= 32'd28) begin
            mem_rdata = {mem[ma], mem[ma + 5'd1], mem[ma + 5'd2], mem[ma + 5'd3]};
        end
    end

    assign got = {p0_gnt, p1_gnt, busy, mem_write, mem_read, mem_addr, mem_wdata,
                  p0_rvalid, p0_rdata, p0_err, p1_rvalid, p1_rdata, p1_err};

    function automatic in_t iv(int r0, int w0, logic [31:0] a0, logic [31:0] d0,
                               int r1, int w1, logic [31:0] a1, logic [31:0] d1);
        in_t x;
        x.r0 = 1'(r0); x.w0 = 1'(w0); x.a0 = a0; x.d0 = d0;
        x.r1 = 1'(r1); x.w1 = 1'(w1); x.a1 = a1; x.d1 = d1;
        return x;
    endfunction

    function automatic out_t ov(int g0, int g1, int bz, int mw, int mr,
                                logic [31:0] maddr, logic [31:0] mdata,
                                int v0, logic [31:0] rd0, int e0,
                                int v1, logic [31:0] rd1, int e1);
        out_t x;
        x.g0 = 1'(g0); x.g1 = 1'(g1); x.busy = 1'(bz); x.mw = 1'(mw); x.mr = 1'(mr);
        x.maddr = maddr; x.mdata = mdata;
        x.v0 = 1'(v0); x.rd0 = rd0; x.e0 = 1'(e0);
        x.v1 = 1'(v1); x.rd1 = rd1; x.e1 = 1'(e1);
        return x;
    endfunction

    task automatic drive(input in_t x);
        p0_req = x.r0; p0_we = x.w0; p0_addr = x.a0; p0_wdata = x.d0;
        p1_req = x.r1; p1_we = x.w1; p1_addr = x.a1; p1_wdata = x.d1;
    endtask

    task automatic check_out(input string name, input out_t g, input out_t e);
        n_tests++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, g, e);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] g, input logic [31:0] e);
        n_tests++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, g, e);
        end
    endtask

    // Issue a single port-0 read after idle and wait (bounded) for its response
    task automatic p0_read_expect(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic seen;
        seen = 1'b0;
        drive(iv(1, 0, addr, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        drive('0);
        for (int k = 0; k < 6 && !seen; k++) begin
            @(negedge clk); #1;
            if (p0_rvalid) seen = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s timeout waiting for p0_rvalid got=0 exp=1", name);
        end else begin
            check32({name, "_data"}, {p0_rdata[31:1], p0_rdata[0] ^ p0_err}, exp);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'(i);

        for (int k = 0; k < 5; k++) begin
            vecs[k].i = '0; vecs[k].o = '0;
        end
        // Port 0 write then read of addr 8
        vecs[5].i  = iv(1, 1, 8, 32'hDEADBEEF, 0, 0, 0, 0);
        vecs[5].o  = ov(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[6].i  = iv(1, 0, 8, 0, 0, 0, 0, 0);
        vecs[6].o  = ov(1, 0, 1, 1, 0, 8, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
        vecs[7].i  = '0;
        vecs[7].o  = ov(0, 0, 1, 0, 1, 8, 0, 1, 0, 0, 0, 0, 0);
        vecs[8].i  = '0;
        vecs[8].o  = ov(0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0, 0, 0);
        vecs[9].i  = '0;
        vecs[9].o  = '0;
        // Port 1: legal write at 28 (boundary), illegal write at 29, read 28
        vecs[10].i = iv(0, 0, 0, 0, 1, 1, 28, 32'hCAFEF00D);
        vecs[10].o = ov(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[11].i = iv(0, 0, 0, 0, 1, 1, 29, 32'h12345678);
        vecs[11].o = ov(0, 1, 1, 1, 0, 28, 32'hCAFEF00D, 0, 0, 0, 0, 0, 0);
        vecs[12].i = iv(0, 0, 0, 0, 1, 0, 28, 0);
        vecs[12].o = ov(0, 1, 1, 0, 0, 29, 32'h12345678, 0, 0, 0, 1, 0, 0);
        vecs[13].i = '0;
        vecs[13].o = ov(0, 0, 1, 0, 1, 28, 0, 0, 0, 0, 1, 0, 1);
        vecs[14].i = '0;
        vecs[14].o = ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFEF00D, 0);
        vecs[15].i = '0;
        vecs[15].o = '0;
        // Contention: p0 reads addr 0, p1 reads addr 4
        for (int k = 16; k < 20; k++) vecs[k].i = iv(1, 0, 0, 0, 1, 0, 4, 0);
        vecs[20].i = iv(0, 0, 0, 0, 1, 0, 4, 0);
        vecs[21].i = '0;
        vecs[22].i = '0;
        vecs[23].i = '0;
`ifdef DMEM_ARB_RR_EN
        vecs[16].o = ov(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[17].o = ov(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[18].o = ov(1, 0, 1, 0, 1, 4, 0, 1, 32'h00010203, 0, 0, 0, 0);
        vecs[19].o = ov(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 1, 32'h04050607, 0);
        vecs[20].o = ov(0, 1, 1, 0, 1, 4, 0, 1, 32'h00010203, 0, 0, 0, 0);
        vecs[21].o = ov(0, 0, 1, 0, 1, 4, 0, 0, 0, 0, 1, 32'h04050607, 0);
        vecs[22].o = ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h04050607, 0);
`else
        vecs[16].o = ov(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[17].o = ov(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[18].o = ov(1, 0, 1, 0, 1, 0, 0, 1, 32'h00010203, 0, 0, 0, 0);
        vecs[19].o = ov(1, 0, 1, 0, 1, 0, 0, 1, 32'h00010203, 0, 0, 0, 0);
        vecs[20].o = ov(0, 1, 1, 0, 1, 0, 0, 1, 32'h00010203, 0, 0, 0, 0);
        vecs[21].o = ov(0, 0, 1, 0, 1, 4, 0, 1, 32'h00010203, 0, 0, 0, 0);
        vecs[22].o = ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h04050607, 0);
`endif
        vecs[23].o = '0;

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        for (int k = 0; k < NV; k++) begin
            drive(vecs[k].i);
            @(negedge clk); #1;
            check_out($sformatf("vec%0d", k), got, vecs[k].o);
            @(posedge clk); #1;
        end

        // Reset during a port-0 read: response dropped, outputs return to reset values
        drive(iv(1, 0, 8, 0, 0, 0, 0, 0));
        @(negedge clk); #1;
        check32("rst_rd_gnt", 32'(p0_gnt), 32'd1);
        @(posedge clk); #1;
        drive('0);
        reset = 1'b1;
        @(negedge clk); #1;
        check32("rst_rd_enables", {30'd0, mem_write, mem_read}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk); #1;
        check_out("rst_rd_after1", got, '0);
        @(posedge clk); #1;
        @(negedge clk); #1;
        check_out("rst_rd_after2", got, '0);
        @(posedge clk); #1;

        // Reset during a port-0 write to addr 12: the write never reaches memory
        drive(iv(1, 1, 12, 32'h55555555, 0, 0, 0, 0));
        @(posedge clk); #1;
        drive('0);
        reset = 1'b1;
        @(negedge clk); #1;
        check32("rst_wr_mem_write", 32'(mem_write), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk); #1;
        check_out("rst_wr_after", got, '0);
        @(posedge clk); #1;

        // Normal service after reset
        p0_read_expect("post_rst_rd8", 8, 32'hDEADBEEF);
        p0_read_expect("post_rst_rd12", 12, 32'h0C0D0E0F);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
